regf_wb_ctrl: RTL and testbench
===============================

Name: regf_wb_ctrl

Overview:
Writeback controller and the single write-side master of the CPU register file. It merges two result sources into the file's one write port (write enable, rd address, rd value):
- single-cycle ALU results (fixed priority, never stalled);
- load returns from the data-memory path (valid/ready, buffered in a small FIFO).
It also keeps a per-register pending-load scoreboard that the hazard unit uses for stall decisions.

Parameters:
XLEN, 32, data width of register values
REG_ADDR_W, 5, register address width
LD_FIFO_DEPTH, 4, load-return buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result present this cycle
alu_rd  in  REG_ADDR_W  ALU destination
alu_data  in  XLEN  ALU result
ld_issue  in  1  load issued to memory this cycle
ld_issue_rd  in  REG_ADDR_W  destination of issued load
ld_valid  in  1  load data return valid
ld_ready  out  1  controller can accept load return
ld_rd  in  REG_ADDR_W  destination of returned load
ld_data  in  XLEN  returned load data
write_regf_en  out  1  register-file write enable
addr_rd  out  REG_ADDR_W  register-file write address
rd_value  out  XLEN  register-file write data
busy  out  2**REG_ADDR_W  bit i = load to xi outstanding
fifo_count  out  $clog2(LD_FIFO_DEPTH)+1  entries buffered

Behaviour:
- Reset (rst low, async): write_regf_en=0, addr_rd=0, rd_value=0, busy=0, FIFO empty, fifo_count=0, ld_ready=0 while asserted. ld_ready=1 in the first cycle after release.
- ld_ready = (fifo_count != LD_FIFO_DEPTH). It is a pure function of registered count, so a pop in the same cycle does not free a slot early.
- Load accept: ld_valid && ld_ready at edge N pushes {ld_rd, ld_data}.
- Output stage is registered. Each cycle exactly one source is selected:
  - alu_valid: ALU wins. Output loads {alu_rd, alu_data}; no FIFO pop.
  - else FIFO non-empty: pop head into output.
  - else: write_regf_en=0; addr_rd/rd_value hold their previous values.
- write_regf_en = selected && (selected rd != 0). Writes to x0 are consumed (popped/accepted) but never enabled.
- Latency:
  - ALU: result presented in cycle N appears on the write port in cycle N+1.
  - Load (no bypass): pushed at edge ending N, head visible N+1, on write port N+2 at the earliest. It is delayed one cycle for each cycle alu_valid blocks it.
- Ordering: loads are written in acceptance order; the FIFO never reorders.
- Simultaneous push and pop in one cycle: count unchanged, head advances, pointers wrap modulo LD_FIFO_DEPTH.
- Scoreboard:
  - ld_issue with ld_issue_rd!=0 sets busy[rd] at the edge.
  - busy[rd] clears on the edge ending the cycle in which that load's write_regf_en is high, so busy is low one cycle after the write.
  - Same edge set and clear of the same register: set wins.
  - busy[0] is always 0.
- Illegal, flagged by SVA assertions in simulation only:
  - ld_issue to a register already busy (issuer must stall);
  - alu_valid with alu_rd busy (WAW; hazard unit stalls);
  - ld_valid with busy[ld_rd]==0.
- Reset mid-operation: FIFO contents, scoreboard and any pending write are discarded. No write is produced after reset assertion.

Optional Feature:
REGF_WB_LD_BYPASS_EN
- Defined: a load accepted in a cycle with the FIFO empty and alu_valid low goes straight into the output register (write port in N+1) and is not pushed.
- Defined, with alu_valid high in that cycle: normal push.
- Undefined: all loads pass through the FIFO (N+2 minimum).
- Scoreboard rules are identical in both builds.

Decomposition:
- Package regf_wb_pkg holds:
  - XLEN and REG_ADDR_W constants;
  - typedef wb_entry_t packed struct {rd, data};
  - typedef wb_src_e enum {WB_NONE, WB_ALU, WB_LD}, used for the select mux and coverage.
- Sub-module regf_wb_fifo: synchronous FIFO of wb_entry_t, DEPTH parameter, push/pop/full/empty/count, same clk/rst.
- Arbitration, scoreboard and output register stay in regf_wb_ctrl.

Test Plan:
- Reset: hold rst low 3 cycles with alu_valid=1 and ld_valid=1 -> write_regf_en=0, busy=0, ld_ready=0; release -> ld_ready=1 next cycle.
- ALU path: alu_valid, rd=5, data=0x1234_5678 in cycle 10 -> write_regf_en=1, addr_rd=5, rd_value=0x12345678 in cycle 11; alu_rd=0 -> write_regf_en=0.
- Load with scoreboard: ld_issue rd=7 -> busy[7]=1. Return 0xDEAD_BEEF in cycle 20 with ALU idle -> write in cycle 22 (21 with bypass); busy[7]=0 in cycle 23.
- ALU priority and ordering: push loads to x1, x2, x3 while alu_valid is held for 4 cycles -> fifo_count reaches 3; then writes x1, x2, x3 in order on consecutive cycles.
- Full boundary: 4 returns with alu_valid held -> fifo_count=4 and ld_ready=0. A 5th ld_valid is not accepted. Drop alu_valid -> one pop, ld_ready=1 the next cycle.
- Set/clear collision: ld_issue rd=9 on the same edge that clears busy[9] -> busy[9] stays 1. Mid-FIFO reset with count=2 -> count=0 and no writes emitted.

Source files
------------

// File: rtl/regf_wb_pkg.sv
// Shared constants and types for the register-file writeback controller.
package regf_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 1 << REG_ADDR_W;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LD
    } wb_src_e;

endpackage

// File: rtl/regf_wb_if.sv
// Bus between the execute/memory stages and the writeback controller.
// master = upstream producer (ALU, load unit, hazard unit); slave = controller.
interface regf_wb_if #(
    parameter int LD_FIFO_DEPTH = 4
);
    import regf_wb_pkg::*;

    localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  write_regf_en;
    logic [REG_ADDR_W-1:0] addr_rd;
    logic [XLEN-1:0]       rd_value;
    logic [NREGS-1:0]      busy;
    logic [CNT_W-1:0]      fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data,
        input  ld_ready, write_regf_en, addr_rd, rd_value, busy, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_valid, ld_rd, ld_data,
        output ld_ready, write_regf_en, addr_rd, rd_value, busy, fifo_count
    );

endinterface

// File: rtl/regf_wb_fifo.sv
// Load-return buffer: small synchronous FIFO of wb_entry_t.
// Caller guarantees no push when full and no pop when empty.
module regf_wb_fifo
    import regf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_data,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    // Next state: write at tail, advance pointers (wrap is free, DEPTH is 2^n).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State register; reset discards all buffered entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/regf_wb_ctrl.sv
// Writeback controller: sole writer of the register file. ALU results take
// the write port unconditionally; load returns queue in a FIFO and drain when
// the ALU is idle. Also tracks outstanding loads per register (busy).
// Optional build macro REGF_WB_LD_BYPASS_EN: a load returning into an empty
// FIFO with the ALU idle goes straight to the output register.
module regf_wb_ctrl
    import regf_wb_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 4,
    localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1
) (
    input logic        clk,
    input logic        rst,
    regf_wb_if.slave   bus
);

    wb_entry_t             alu_ent, ld_ent, head, sel_ent;
    wb_src_e               src;
    logic                  accept, bypass, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic                  run_q, run_d;
    logic                  wen_q, wen_d;
    logic                  wr_ld_q, wr_ld_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic [NREGS-1:0]      busy_q, busy_d;

    assign alu_ent = '{rd: bus.alu_rd, data: bus.alu_data};
    assign ld_ent  = '{rd: bus.ld_rd,  data: bus.ld_data};

    // Ready only from registered state, so a same-cycle pop never frees a slot
    // early; run_q holds it low until the first edge after reset release.
    assign bus.ld_ready = run_q && !fifo_full;
    assign accept       = bus.ld_valid && bus.ld_ready;

`ifdef REGF_WB_LD_BYPASS_EN
    assign bypass = accept && fifo_empty && !bus.alu_valid;
`else
    assign bypass = 1'b0;
`endif
    assign push = accept && !bypass;

    regf_wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ld_ent),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Source select: ALU first, then buffered loads, then a bypassed load.
    always_comb begin
        src     = WB_NONE;
        pop     = 1'b0;
        sel_ent = ld_ent;
        if (bus.alu_valid) begin
            src     = WB_ALU;
            sel_ent = alu_ent;
        end else if (!fifo_empty) begin
            src     = WB_LD;
            pop     = 1'b1;
            sel_ent = head;
        end else if (bypass) begin
            src     = WB_LD;
            sel_ent = ld_ent;
        end
    end

    // Output register next state and busy scoreboard (set beats clear).
    always_comb begin
        run_d   = 1'b1;
        wen_d   = (src != WB_NONE) && (sel_ent.rd != '0);
        wr_ld_d = (src == WB_LD);
        addr_d  = (src != WB_NONE) ? sel_ent.rd   : addr_q;
        data_d  = (src != WB_NONE) ? sel_ent.data : data_q;
        busy_d  = busy_q;
        if (wen_q && wr_ld_q) busy_d[addr_q] = 1'b0;
        if (bus.ld_issue && bus.ld_issue_rd != '0) busy_d[bus.ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Output register and scoreboard state; reset drops any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= 1'b0;
            wen_q   <= 1'b0;
            wr_ld_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= '0;
        end else begin
            run_q   <= run_d;
            wen_q   <= wen_d;
            wr_ld_q <= wr_ld_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.write_regf_en = wen_q;
    assign bus.addr_rd       = addr_q;
    assign bus.rd_value      = data_q;
    assign bus.busy          = busy_q;
    assign bus.fifo_count    = fifo_count;

    // Issuer must stall on a busy register, unless that register is being
    // released by its load write on this same edge.
    a_issue_busy: assert property (@(posedge clk) disable iff (!rst)
        (bus.ld_issue && bus.ld_issue_rd != '0) |->
        (!busy_q[bus.ld_issue_rd] || (wen_q && wr_ld_q && addr_q == bus.ld_issue_rd)));

    a_alu_waw: assert property (@(posedge clk) disable iff (!rst)
        bus.alu_valid |-> !busy_q[bus.alu_rd]);

    a_ld_unexpected: assert property (@(posedge clk) disable iff (!rst)
        bus.ld_valid |-> busy_q[bus.ld_rd]);

    c_ld_drain_while_push: cover property (@(posedge clk) disable iff (!rst)
        src == WB_LD && push);

endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Testbench for regf_wb_ctrl: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model through a scoreboard.
module tb_regf_wb_ctrl;
    import regf_wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef REGF_WB_LD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regf_wb_if #(.LD_FIFO_DEPTH(DEPTH)) bus ();
    regf_wb_ctrl #(.LD_FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_t;

    typedef struct {
        bit          wen;
        logic [4:0]  addr;
        logic [31:0] data;
        bit          rdy;
        int          cnt;
        logic [31:0] busy;
    } exp_t;

    exp_t        exp_q[$];
    ld_t         m_fifo[$];
    logic [31:0] m_busy = '0;
    bit          m_run = 0, m_wen = 0, m_wr_ld = 0, m_last_acc = 0, started = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    function automatic exp_t snap();
        exp_t e;
        e.wen  = m_wen;
        e.addr = m_addr;
        e.data = m_data;
        e.rdy  = m_run && (m_fifo.size() != DEPTH);
        e.cnt  = m_fifo.size();
        e.busy = m_busy;
        return e;
    endfunction

    bit          s_rdy, s_acc, s_byp, s_sel, s_ld;
    logic [4:0]  s_rd;
    logic [31:0] s_d;
    ld_t         s_e;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_fifo.delete();
            m_busy = '0; m_run = 0; m_wen = 0; m_wr_ld = 0;
            m_addr = '0; m_data = '0; m_last_acc = 0;
            exp_q.delete();
        end else begin
            s_rdy = m_run && (m_fifo.size() != DEPTH);
            s_acc = bus.ld_valid && s_rdy;
            s_byp = BYP && s_acc && (m_fifo.size() == 0) && !bus.alu_valid;
            if (m_wen && m_wr_ld) m_busy[m_addr] = 1'b0;
            if (bus.ld_issue && bus.ld_issue_rd != 0) m_busy[bus.ld_issue_rd] = 1'b1;
            s_sel = 1; s_ld = 0; s_rd = '0; s_d = '0;
            if (bus.alu_valid) begin
                s_rd = bus.alu_rd; s_d = bus.alu_data;
            end else if (m_fifo.size() > 0) begin
                s_e = m_fifo.pop_front(); s_rd = s_e.rd; s_d = s_e.data; s_ld = 1;
            end else if (s_byp) begin
                s_rd = bus.ld_rd; s_d = bus.ld_data; s_ld = 1;
            end else begin
                s_sel = 0;
            end
            if (s_acc && !s_byp) m_fifo.push_back(ld_t'{rd: bus.ld_rd, data: bus.ld_data});
            m_wen   = s_sel && (s_rd != 0);
            m_wr_ld = s_sel && s_ld;
            if (s_sel) begin m_addr = s_rd; m_data = s_d; end
            m_last_acc = s_acc;
            m_run = 1;
        end
        exp_q.push_back(snap());
        started = 1;
    end

    // ---------------- monitor ----------------
    exp_t x;
    initial forever begin
        @(negedge clk);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("wen",      32'(bus.write_regf_en), 32'(x.wen));
            chk("addr_rd",  32'(bus.addr_rd),       32'(x.addr));
            chk("rd_value", bus.rd_value,           x.data);
            chk("ld_ready", 32'(bus.ld_ready),      32'(x.rdy));
            chk("count",    32'(bus.fifo_count),    32'(x.cnt));
            chk("busy",     bus.busy,               x.busy);
        end else if (started) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    ld_t pend[$];

    task automatic cyc(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit iss, input logic [4:0] ir, input bit ret);
        bus.alu_valid   = av;
        bus.alu_rd      = ar;
        bus.alu_data    = ad;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = $urandom;
        if (ret && pend.size() > 0) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = pend[0].rd;
            bus.ld_data  = pend[0].data;
        end
        bus.ld_issue    = iss;
        bus.ld_issue_rd = ir;
        if (iss && ir != 0) pend.push_back(ld_t'{rd: ir, data: $urandom});
        @(posedge clk);
        #1;
        if (m_last_acc) void'(pend.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, 0);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (!(pend.size() == 0 && m_fifo.size() == 0 && !m_wen && m_busy == 0) && k < 300) begin
            cyc(0, '0, '0, 0, '0, 1);
            k++;
        end
        chk(nm, 32'(pend.size() + m_fifo.size() + int'(m_wen) + $countones(m_busy)), 32'd0);
    endtask

    bit          av, iss, ret;
    logic [4:0]  ar, ir;
    int          k;

    initial begin
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h55;
        bus.ld_valid = 1; bus.ld_rd = 5'd4; bus.ld_data = 32'h66;
        bus.ld_issue = 0; bus.ld_issue_rd = '0;

        // Reset held 3 cycles with traffic on the inputs.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen",   32'(bus.write_regf_en), 32'd0);
        chk("rst_busy",  bus.busy, 32'd0);
        chk("rst_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        rst = 1'b1;
        bus.alu_valid = 0; bus.ld_valid = 0;
        @(posedge clk); #1;
        chk("ready_after_rel", 32'(bus.ld_ready), 32'd1);

        // ALU path and x0 suppression.
        cyc(1, 5'd5, 32'h1234_5678, 0, '0, 0);
        chk("alu_wen",  32'(bus.write_regf_en), 32'd1);
        chk("alu_addr", 32'(bus.addr_rd), 32'd5);
        chk("alu_data", bus.rd_value, 32'h1234_5678);
        cyc(1, 5'd0, 32'hAAAA_0000, 0, '0, 0);
        chk("alu_x0_wen", 32'(bus.write_regf_en), 32'd0);
        idle(1);

        // Load with scoreboard.
        cyc(0, '0, '0, 1, 5'd7, 0);
        chk("busy7_set", 32'(bus.busy[7]), 32'd1);
        idle(1);
        pend[0].data = 32'hDEAD_BEEF;
        cyc(0, '0, '0, 0, '0, 1);
        if (!BYP) begin
            chk("ld_not_yet", 32'(bus.write_regf_en), 32'd0);
            idle(1);
        end
        chk("ld_wen",  32'(bus.write_regf_en), 32'd1);
        chk("ld_addr", 32'(bus.addr_rd), 32'd7);
        chk("ld_data", bus.rd_value, 32'hDEAD_BEEF);
        idle(1);
        chk("busy7_clr", 32'(bus.busy[7]), 32'd0);

        // ALU priority and load ordering.
        cyc(0, '0, '0, 1, 5'd1, 0);
        cyc(0, '0, '0, 1, 5'd2, 0);
        cyc(0, '0, '0, 1, 5'd3, 0);
        for (int i = 0; i < 3; i++) cyc(1, 5'd10, $urandom, 0, '0, 1);
        chk("count3", 32'(bus.fifo_count), 32'd3);
        cyc(1, 5'd10, $urandom, 0, '0, 1);
        idle(1);
        chk("order1", 32'(bus.addr_rd), 32'd1);
        idle(1);
        chk("order2", 32'(bus.addr_rd), 32'd2);
        idle(1);
        chk("order3", 32'(bus.addr_rd), 32'd3);
        drain("drain_order");

        // Full boundary.
        for (int i = 11; i < 15; i++) cyc(0, '0, '0, 1, 5'(i), 0);
        cyc(1, 5'd10, $urandom, 1, 5'd15, 1);
        for (int i = 0; i < 3; i++) cyc(1, 5'd10, $urandom, 0, '0, 1);
        chk("full_count", 32'(bus.fifo_count), 32'd4);
        chk("full_ready", 32'(bus.ld_ready), 32'd0);
        cyc(1, 5'd10, $urandom, 0, '0, 1);
        chk("full_no_accept", 32'(bus.fifo_count), 32'd4);
        cyc(0, '0, '0, 0, '0, 1);
        chk("pop_count", 32'(bus.fifo_count), 32'd3);
        chk("pop_ready", 32'(bus.ld_ready), 32'd1);
        drain("drain_full");

        // Set/clear collision on x9.
        cyc(0, '0, '0, 1, 5'd9, 0);
        cyc(0, '0, '0, 0, '0, 1);
        k = 0;
        while (!(m_wen && m_wr_ld && m_addr == 5'd9) && k < 10) begin idle(1); k++; end
        chk("x9_write_seen", 32'(bus.write_regf_en && bus.addr_rd == 5'd9), 32'd1);
        cyc(0, '0, '0, 1, 5'd9, 0);
        chk("busy9_set_wins", 32'(bus.busy[9]), 32'd1);
        drain("drain_coll");

        // Reset with two entries buffered.
        cyc(0, '0, '0, 1, 5'd20, 0);
        cyc(0, '0, '0, 1, 5'd21, 0);
        cyc(1, 5'd10, $urandom, 0, '0, 1);
        cyc(1, 5'd10, $urandom, 0, '0, 1);
        chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        bus.alu_valid = 0; bus.ld_valid = 0; bus.ld_issue = 0;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("mid_rst_wen",   32'(bus.write_regf_en), 32'd0);
        pend.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(4);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            av  = ($urandom_range(9) < 4);
            ar  = 5'($urandom_range(31));
            if (m_busy[ar]) av = 0;
            iss = ($urandom_range(9) < 3);
            ir  = 5'($urandom_range(31, 1));
            if (m_busy[ir]) iss = 0;
            ret = ($urandom_range(9) < 5);
            cyc(av, ar, $urandom, iss, ir, ret);
        end
        drain("drain_rand");
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
